// File: rtl/user_param_ctrl.sv
// Push-button tuning controller: debounced inc/dec/select buttons drive NUM_CH
// saturating WIDTH-bit values, with hold-to-auto-repeat stepping.
module user_param_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int WIDTH         = 8,
  parameter int RST_VAL       = 16,
  parameter int MIN_VAL       = 0,
  parameter int MAX_VAL       = 255,
  parameter int STEP          = 1,
  parameter int DB_DELAY      = 240000,
  parameter int HOLD_DELAY    = 12000000,
  parameter int REPEAT_PERIOD = 2400000,
  localparam int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_btn_inc,
  input  logic                    i_btn_dec,
  input  logic                    i_btn_sel,
  output logic [SEL_W-1:0]        o_sel,
  output logic [NUM_CH*WIDTH-1:0] o_values,
  output logic                    o_update,
  output logic [SEL_W-1:0]        o_update_ch
);

  localparam int DB_W    = $clog2(DB_DELAY);
  localparam int TMR_MAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MIN_W  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_VAL);

  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT} step_st_e;

  // Button index: 0 = inc, 1 = dec, 2 = sel
  logic [2:0]       raw;
  logic [2:0]       sync1_q, sync2_q, stable_q, stable_d, stable_prev_q, rise;
  logic [DB_W-1:0]  db_cnt_q [3];
  logic [DB_W-1:0]  db_cnt_d [3];
  step_st_e         st_q [2];
  step_st_e         st_d [2];
  logic [TMR_W-1:0] tmr_q [2];
  logic [TMR_W-1:0] tmr_d [2];
  logic [1:0]       step;
  logic [WIDTH-1:0] vals_q [NUM_CH];
  logic [WIDTH-1:0] vals_d [NUM_CH];
  logic [SEL_W-1:0] sel_q, sel_d, upd_ch_q, upd_ch_d;
  logic             upd_q, upd_d;
  logic [WIDTH:0]   cur, nxt;

  assign raw  = {i_btn_sel, i_btn_dec, i_btn_inc};
  assign rise = stable_q & ~stable_prev_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_DELAY - 1)) stable_d[i] = ~stable_q[i];
        else                                     db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
  end

  // A select rise cancels any hold/repeat and suppresses stepping that cycle
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      tmr_d[i] = tmr_q[i];
      step[i]  = 1'b0;
      if (rise[2]) begin
        st_d[i]  = ST_IDLE;
        tmr_d[i] = '0;
      end else begin
        case (st_q[i])
          ST_IDLE: begin
            if (rise[i]) begin
              step[i]  = 1'b1;
              tmr_d[i] = '0;
              st_d[i]  = ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (!stable_q[i]) begin
              st_d[i]  = ST_IDLE;
              tmr_d[i] = '0;
            end else if (tmr_q[i] == TMR_W'(HOLD_DELAY - 1)) begin
              step[i]  = 1'b1;
              tmr_d[i] = '0;
              st_d[i]  = ST_REPEAT;
            end else begin
              tmr_d[i] = tmr_q[i] + TMR_W'(1);
            end
          end
          ST_REPEAT: begin
            if (!stable_q[i]) begin
              st_d[i]  = ST_IDLE;
              tmr_d[i] = '0;
            end else if (tmr_q[i] == TMR_W'(REPEAT_PERIOD - 1)) begin
              step[i]  = 1'b1;
              tmr_d[i] = '0;
            end else begin
              tmr_d[i] = tmr_q[i] + TMR_W'(1);
            end
          end
          default: begin
            st_d[i]  = ST_IDLE;
            tmr_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    sel_d    = sel_q;
    upd_d    = 1'b0;
    upd_ch_d = upd_ch_q;
    cur      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      vals_d[k] = vals_q[k];
      if (SEL_W'(k) == sel_q) cur = {1'b0, vals_q[k]};
    end
    if (step[0]) nxt = ((cur + STEP_W) > MAX_W) ? MAX_W : cur + STEP_W;
    else         nxt = (cur < (MIN_W + STEP_W)) ? MIN_W : cur - STEP_W;
    if (rise[2]) sel_d = (sel_q == SEL_W'(NUM_CH - 1)) ? '0 : sel_q + SEL_W'(1);
    // Opposing steps in the same cycle cancel; saturation yields no change
    if ((step[0] ^ step[1]) && (nxt != cur)) begin
      for (int k = 0; k < NUM_CH; k++)
        if (SEL_W'(k) == sel_q) vals_d[k] = nxt[WIDTH-1:0];
      upd_d    = 1'b1;
      upd_ch_d = sel_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      sel_q         <= '0;
      upd_q         <= 1'b0;
      upd_ch_q      <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= ST_IDLE;
        tmr_q[i] <= '0;
      end
      for (int k = 0; k < NUM_CH; k++) vals_q[k] <= WIDTH'(RST_VAL);
    end else begin
      sync1_q       <= raw;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      sel_q         <= sel_d;
      upd_q         <= upd_d;
      upd_ch_q      <= upd_ch_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int i = 0; i < 2; i++) begin
        st_q[i]  <= st_d[i];
        tmr_q[i] <= tmr_d[i];
      end
      for (int k = 0; k < NUM_CH; k++) vals_q[k] <= vals_d[k];
    end
  end

  always_comb begin
    o_values = '0;
    for (int k = 0; k < NUM_CH; k++) o_values[k*WIDTH +: WIDTH] = vals_q[k];
  end

  assign o_sel       = sel_q;
  assign o_update    = upd_q;
  assign o_update_ch = upd_ch_q;

endmodule

// File: tb/tb_user_param_ctrl.sv
// Bench for user_param_ctrl: directed and random button activity compared every
// cycle against a timing-level behavioural model of the controller.
module tb_user_param_ctrl;

  localparam int NC   = 3;
  localparam int W    = 6;
  localparam int RSTV = 16;
  localparam int MINV = 5;
  localparam int MAXV = 41;
  localparam int STP  = 3;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int RP   = 3;
  localparam int SW   = 2;

  logic            i_clk, i_rstn, i_btn_inc, i_btn_dec, i_btn_sel;
  logic [SW-1:0]   o_sel, o_update_ch;
  logic [NC*W-1:0] o_values;
  logic            o_update;

  user_param_ctrl #(
    .NUM_CH(NC), .WIDTH(W), .RST_VAL(RSTV), .MIN_VAL(MINV), .MAX_VAL(MAXV),
    .STEP(STP), .DB_DELAY(DB), .HOLD_DELAY(HOLD), .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_btn_inc(i_btn_inc), .i_btn_dec(i_btn_dec),
    .i_btn_sel(i_btn_sel), .o_sel(o_sel), .o_values(o_values),
    .o_update(o_update), .o_update_ch(o_update_ch)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a press is "active" from its first step; steps fall at age 0,
  // HOLD, HOLD+RP, HOLD+2*RP ... while the debounced level stays high.
  int m_val [NC];
  int m_sel, m_upd_ch, m_v, m_nv;
  bit m_upd, m_srise;
  bit m_s1 [3];
  bit m_s2 [3];
  bit m_stab [3];
  bit m_prev [3];
  int m_cnt [3];
  bit m_act [2];
  int m_age [2];
  bit m_st [2];
  bit m_raw [3];

  always @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < NC; k++) m_val[k] = RSTV;
      m_sel = 0; m_upd = 0; m_upd_ch = 0;
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_stab[i] = 0; m_prev[i] = 0; m_cnt[i] = 0;
      end
      for (int b = 0; b < 2; b++) begin m_act[b] = 0; m_age[b] = 0; end
    end else begin
      m_srise = m_stab[2] && !m_prev[2];
      for (int b = 0; b < 2; b++) begin
        m_st[b] = 0;
        if (m_srise) m_act[b] = 0;
        else if (!m_act[b]) begin
          if (m_stab[b] && !m_prev[b]) begin m_st[b] = 1; m_act[b] = 1; m_age[b] = 0; end
        end else if (!m_stab[b]) m_act[b] = 0;
        else begin
          m_age[b]++;
          if (m_age[b] == HOLD || (m_age[b] > HOLD && (m_age[b] - HOLD) % RP == 0)) m_st[b] = 1;
        end
      end
      m_upd = 0;
      if (m_srise) m_sel = (m_sel + 1) % NC;
      if (m_st[0] != m_st[1]) begin
        m_v  = m_val[m_sel];
        m_nv = m_st[0] ? ((m_v + STP > MAXV) ? MAXV : m_v + STP)
                       : ((m_v - STP < MINV) ? MINV : m_v - STP);
        if (m_nv != m_v) begin
          m_val[m_sel] = m_nv; m_upd = 1; m_upd_ch = m_sel;
        end
      end
      m_raw[0] = i_btn_inc; m_raw[1] = i_btn_dec; m_raw[2] = i_btn_sel;
      for (int i = 0; i < 3; i++) begin
        m_prev[i] = m_stab[i];
        if (m_s2[i] != m_stab[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DB) begin m_stab[i] = !m_stab[i]; m_cnt[i] = 0; end
        end else m_cnt[i] = 0;
        m_s2[i] = m_s1[i];
        m_s1[i] = m_raw[i];
      end
    end
  end

  bit chk_en = 0;
  always @(negedge i_clk) begin
    if (chk_en) begin
      for (int k = 0; k < NC; k++) chk("value", 32'(o_values[k*W +: W]), 32'(m_val[k]));
      chk("sel", 32'(o_sel), 32'(m_sel));
      chk("update", 32'(o_update), 32'(m_upd));
      if (m_upd) chk("update_ch", 32'(o_update_ch), 32'(m_upd_ch));
    end
  end

  task automatic press(input logic [2:0] b, input int n, input int gap);
    @(negedge i_clk);
    {i_btn_sel, i_btn_dec, i_btn_inc} = b;
    repeat (n) @(negedge i_clk);
    {i_btn_sel, i_btn_dec, i_btn_inc} = 3'b000;
    repeat (gap) @(negedge i_clk);
  endtask

  int lat;
  logic [2:0] rb;

  initial begin
    i_rstn = 1'b0; i_btn_inc = 1'b0; i_btn_dec = 1'b0; i_btn_sel = 1'b0;
    @(negedge i_clk);
    chk_en = 1;
    @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);

    // press-to-update latency, counted in edges from the first high sample
    i_btn_inc = 1'b1;
    lat = -1;
    for (int e = 0; e < 20 && lat < 0; e++) begin
      @(negedge i_clk);
      if (o_update) lat = e;
    end
    chk("press_latency", 32'(lat), 32'(DB + 2));
    repeat (2) @(negedge i_clk);
    i_btn_inc = 1'b0;
    repeat (15) @(negedge i_clk);

    press(3'b010, 2, 12);           // glitch on dec
    press(3'b001, 30, 15);          // long hold with repeats
    press(3'b001, 60, 15);          // run into the upper bound
    press(3'b001, 8, 15);           // saturated press
    press(3'b010, 90, 15);          // down to the lower bound
    press(3'b010, 8, 15);
    repeat (3) press(3'b100, 7, 10);  // three selects wrap NC=3
    press(3'b100, 7, 10);
    press(3'b001, 8, 15);           // channel 1
    press(3'b100, 7, 10);
    press(3'b001, 25, 15);          // channel 2

    // select during an inc hold cancels repeating
    @(negedge i_clk);
    i_btn_inc = 1'b1;
    repeat (22) @(negedge i_clk);
    i_btn_sel = 1'b1;
    repeat (8) @(negedge i_clk);
    i_btn_sel = 1'b0;
    repeat (20) @(negedge i_clk);
    i_btn_inc = 1'b0;
    repeat (15) @(negedge i_clk);

    press(3'b011, 30, 15);          // simultaneous inc and dec

    // reset mid-hold
    @(negedge i_clk);
    i_btn_inc = 1'b1;
    repeat (18) @(negedge i_clk);
    i_rstn = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (20) @(negedge i_clk);
    i_btn_inc = 1'b0;
    repeat (15) @(negedge i_clk);

    for (int it = 0; it < 300; it++) begin
      rb = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 3) == 0) rb = 3'b001;
      else if ($urandom_range(0, 3) == 0) rb = 3'b010;
      if ($urandom_range(0, 39) == 0) begin
        @(negedge i_clk);
        i_rstn = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
      end
      press(rb, $urandom_range(1, 30), $urandom_range(0, 12));
    end
    repeat (15) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
